// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the
// single-port memory. The arbiter uses the slave view; requesters and the
// memory model use the master view.
interface mem_arbiter_if;
  // boot loader port (write-only)
  logic        boot_req;
  logic [3:0]  boot_w_enb;
  logic [31:0] boot_addr;
  logic [31:0] boot_w_data;
  logic        boot_ack;
  // core data port
  logic        d_req;
  logic [3:0]  d_w_enb;
  logic [31:0] d_addr;
  logic [31:0] d_w_data;
  logic [31:0] d_r_data;
  logic        d_ack;
  // core fetch port (read-only)
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_r_data;
  logic        i_ack;
  logic        i_misalign;
  logic        addr_err;
  // memory side
  logic [3:0]  mem_w_enb;
  logic        mem_r_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  // status
  logic        busy;
  logic [1:0]  grant_id;

  modport slave (
    input  boot_req, boot_w_enb, boot_addr, boot_w_data,
    input  d_req, d_w_enb, d_addr, d_w_data,
    input  i_req, i_addr,
    input  mem_r_data,
    output boot_ack, d_r_data, d_ack, i_r_data, i_ack, i_misalign, addr_err,
    output mem_w_enb, mem_r_enb, mem_addr, mem_w_data,
    output busy, grant_id
  );

  modport master (
    output boot_req, boot_w_enb, boot_addr, boot_w_data,
    output d_req, d_w_enb, d_addr, d_w_data,
    output i_req, i_addr,
    output mem_r_data,
    input  boot_ack, d_r_data, d_ack, i_r_data, i_ack, i_misalign, addr_err,
    input  mem_w_enb, mem_r_enb, mem_addr, mem_w_data,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the boot loader, the
// core data path and the core instruction fetch. One transaction at a time,
// fixed priority boot > data > fetch, with a starvation counter that lets a
// waiting fetch overtake data after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int ADDR_BITS  = 10,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_BOOT  = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;
  localparam logic [1:0] OWN_FETCH = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_MAX);
  localparam logic [2:0]       WAIT_LAST = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       wenb_q, wenb_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       wait_q, wait_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic [31:0]      i_rdata_q, i_rdata_d;

  logic [1:0]       winner;
  logic             is_write;
  logic             done;

  // Fixed-priority arbitration; a starved fetch overtakes data but never boot.
  always_comb begin
    winner = OWN_NONE;
    if (bus.boot_req) begin
      winner = OWN_BOOT;
    end else if (bus.i_req && (cnt_q == CNT_MAX)) begin
      winner = OWN_FETCH;
    end else if (bus.d_req) begin
      winner = OWN_DATA;
    end else if (bus.i_req) begin
      winner = OWN_FETCH;
    end
  end

  // Boot is always a write (possibly with no lanes enabled); fetch latches zero enables.
  assign is_write = (grant_q == OWN_BOOT) || (wenb_q != 4'h0);

  // Next-state, grant latching, starvation counter and read-data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wenb_d    = wenb_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    d_rdata_d = d_rdata_q;
    i_rdata_d = i_rdata_q;

    unique case (state_q)
      IDLE: begin
        case (winner)
          OWN_BOOT: cnt_d = cnt_q;
          OWN_DATA: begin
            if (bus.i_req) begin
              cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
              cnt_d = '0;
            end
          end
          default: cnt_d = '0;
        endcase

        case (winner)
          OWN_BOOT: begin
            addr_d  = bus.boot_addr;
            wenb_d  = bus.boot_w_enb;
            wdata_d = bus.boot_w_data;
          end
          OWN_DATA: begin
            addr_d  = bus.d_addr;
            wenb_d  = bus.d_w_enb;
            wdata_d = bus.d_w_data;
          end
          OWN_FETCH: begin
            addr_d  = bus.i_addr;
            wenb_d  = 4'h0;
          end
          default: ;
        endcase

        if (winner != OWN_NONE) begin
          grant_d = winner;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        wait_d = 3'd0;
        if (is_write) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          if (grant_q == OWN_DATA) begin
            d_rdata_d = bus.mem_r_data;
          end else begin
            i_rdata_d = bus.mem_r_data;
          end
          state_d = DONE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      DONE: begin
        grant_d = OWN_NONE;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= OWN_NONE;
      addr_q    <= 32'h0;
      wenb_q    <= 4'h0;
      wdata_q   <= 32'h0;
      wait_q    <= 3'd0;
      d_rdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wenb_q    <= wenb_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  assign done = (state_q == DONE);

  // Memory strobes only in ACCESS; address and write data simply hold the latches.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_w_data = wdata_q;
  assign bus.mem_w_enb  = ((state_q == ACCESS) && is_write) ? wenb_q : 4'h0;
  assign bus.mem_r_enb  = (state_q == ACCESS) && !is_write;

  assign bus.boot_ack   = done && (grant_q == OWN_BOOT);
  assign bus.d_ack      = done && (grant_q == OWN_DATA);
  assign bus.i_ack      = done && (grant_q == OWN_FETCH);
  assign bus.i_misalign = bus.i_ack && (addr_q[1:0] != 2'b00);
  assign bus.addr_err   = done && (|addr_q[31:ADDR_BITS+2]);

  assign bus.d_r_data   = d_rdata_q;
  assign bus.i_r_data   = i_rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: u_dut (READ_LAT=1) carries the main
// directed sequence against a byte-lane memory model; u_dut3 (READ_LAT=3)
// is used for the asynchronous reset during a read.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n1 = 1'b1;
  logic rst_n3 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.ADDR_BITS(10), .READ_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk (clk),
    .rst (rst_n1),
    .bus (bus1)
  );

  mem_arbiter #(.ADDR_BITS(10), .READ_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk (clk),
    .rst (rst_n3),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model for u_dut: 1-cycle synchronous read, byte-lane writes.
  logic [31:0] mem1 [0:1023];
  logic [31:0] rd1;
  int          wr_cnt1 = 0;

  always @(posedge clk) begin
    if (bus1.mem_r_enb) rd1 <= mem1[bus1.mem_addr[11:2]];
    if (|bus1.mem_w_enb) wr_cnt1 <= wr_cnt1 + 1;
    for (int b = 0; b < 4; b++) begin
      if (bus1.mem_w_enb[b]) mem1[bus1.mem_addr[11:2]][b*8 +: 8] <= bus1.mem_w_data[b*8 +: 8];
    end
  end

  assign bus1.mem_r_data = rd1;
  assign bus3.mem_r_data = 32'hC0DE_0003;

  typedef struct {
    int          dut;
    int          port;
    bit          rd;
    logic [31:0] rdata;
    logic        mis;
    logic        aerr;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int port, input bit rd, input logic [31:0] rdata,
                      input logic mis, input logic aerr, input int c);
    exp_t e;
    e.dut = dut; e.port = port; e.rd = rd; e.rdata = rdata;
    e.mis = mis; e.aerr = aerr; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic mon(input int dut, input logic b, input logic d, input logic i,
                     input logic [31:0] drd, input logic [31:0] ird,
                     input logic mis, input logic aerr, input logic [1:0] gid);
    exp_t e;
    int   port;
    if (b || d || i) begin
      port = b ? 1 : (d ? 2 : 3);
      chk("ack_onehot", $countones({b, d, i}), 1);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack dut=%0d port=%0d actual=ack required=none (cycle %0d)", dut, port, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ack_dut", dut, e.dut);
        chk("ack_port", port, e.port);
        chk("ack_grant_id", gid, e.port);
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_misalign", mis, e.mis);
        chk("ack_addr_err", aerr, e.aerr);
        if (e.rd) chk("ack_rdata", (port == 2) ? drd : ird, e.rdata);
      end
    end else if (mis || aerr) begin
      checks++;
      errors++;
      $display("FAIL flag_without_ack dut=%0d actual=%b%b required=00 (cycle %0d)", dut, mis, aerr, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever either DUT pulses an ack.
  always @(negedge clk) begin
    mon(1, bus1.boot_ack, bus1.d_ack, bus1.i_ack, bus1.d_r_data, bus1.i_r_data,
        bus1.i_misalign, bus1.addr_err, bus1.grant_id);
    mon(3, bus3.boot_ack, bus3.d_ack, bus3.i_ack, bus3.d_r_data, bus3.i_r_data,
        bus3.i_misalign, bus3.addr_err, bus3.grant_id);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on u_dut, issued while it is IDLE.
  task automatic issue1(input int port, input logic [31:0] addr, input logic [3:0] wenb,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic mis, input logic aerr);
    bit rd;
    int lat;
    rd  = (port == 3) || (port == 2 && wenb == 4'h0);
    lat = rd ? 3 : 2;
    push(1, port, rd, rdata, mis, aerr, cyc + lat);
    case (port)
      1: begin
        bus1.boot_req = 1'b1; bus1.boot_addr = addr;
        bus1.boot_w_enb = wenb; bus1.boot_w_data = wdata;
      end
      2: begin
        bus1.d_req = 1'b1; bus1.d_addr = addr;
        bus1.d_w_enb = wenb; bus1.d_w_data = wdata;
      end
      default: begin
        bus1.i_req = 1'b1; bus1.i_addr = addr;
      end
    endcase
    tick();
    chk("access_grant_id", bus1.grant_id, port);
    chk("access_mem_addr", bus1.mem_addr, addr);
    chk("access_mem_w_enb", bus1.mem_w_enb, rd ? 4'h0 : wenb);
    chk("access_mem_r_enb", bus1.mem_r_enb, rd);
    if (!rd) chk("access_mem_w_data", bus1.mem_w_data, wdata);
    repeat (lat - 1) tick();
    bus1.boot_req = 1'b0;
    bus1.d_req    = 1'b0;
    bus1.i_req    = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int wr_before;
    bit fetch;

    bus1.boot_req = 0; bus1.boot_w_enb = 0; bus1.boot_addr = 0; bus1.boot_w_data = 0;
    bus1.d_req = 0; bus1.d_w_enb = 0; bus1.d_addr = 0; bus1.d_w_data = 0;
    bus1.i_req = 0; bus1.i_addr = 0;
    bus3.boot_req = 0; bus3.boot_w_enb = 0; bus3.boot_addr = 0; bus3.boot_w_data = 0;
    bus3.d_req = 0; bus3.d_w_enb = 0; bus3.d_addr = 0; bus3.d_w_data = 0;
    bus3.i_req = 0; bus3.i_addr = 0;

    // reset state, checked before any clock edge
    #1;
    rst_n1 = 1'b0;
    rst_n3 = 1'b0;
    #1;
    chk("rst_busy", bus1.busy, 1'b0);
    chk("rst_grant_id", bus1.grant_id, 2'd0);
    chk("rst_mem_w_enb", bus1.mem_w_enb, 4'h0);
    chk("rst_mem_r_enb", bus1.mem_r_enb, 1'b0);
    chk("rst_mem_addr", bus1.mem_addr, 32'h0);
    chk("rst_mem_w_data", bus1.mem_w_data, 32'h0);
    chk("rst_d_r_data", bus1.d_r_data, 32'h0);
    chk("rst_i_r_data", bus1.i_r_data, 32'h0);
    chk("rst_acks", {bus1.boot_ack, bus1.d_ack, bus1.i_ack}, 3'b000);
    chk("rst_flags", {bus1.i_misalign, bus1.addr_err}, 2'b00);
    chk("rst_busy3", bus3.busy, 1'b0);
    tick();
    tick();
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    tick();

    // data write then fetch read of the same word
    issue1(2, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    issue1(3, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // misaligned fetch still uses the full address
    issue1(2, 32'h100, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0);
    issue1(3, 32'h102, 4'h0, 32'h0, 32'h12345678, 1'b1, 1'b0);

    // out-of-range write executes (aliases to word 0 in a 1K-word memory)
    issue1(2, 32'h1000, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
    issue1(2, 32'h0, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);

    // partial byte-lane write
    issue1(2, 32'h10, 4'b0011, 32'h0000CAFE, 32'h0, 1'b0, 1'b0);
    issue1(2, 32'h10, 4'h0, 32'h0, 32'hDEADCAFE, 1'b0, 1'b0);

    // boot no-op write: acked, no memory write strobe
    wr_before = wr_cnt1;
    issue1(1, 32'h20, 4'h0, 32'h11111111, 32'h0, 1'b0, 1'b0);
    chk("boot_noop_writes", wr_cnt1, wr_before);
    issue1(1, 32'h20, 4'hF, 32'h22222222, 32'h0, 1'b0, 1'b0);
    issue1(2, 32'h20, 4'h0, 32'h0, 32'h22222222, 1'b0, 1'b0);

    // out-of-range fetch flags addr_err
    issue1(3, 32'h2000_0010, 4'h0, 32'h0, 32'hDEADCAFE, 1'b0, 1'b1);

    // simultaneous boot, data and fetch: served 1, 2, 3
    k = cyc;
    push(1, 1, 1'b0, 32'h0, 1'b0, 1'b0, k + 2);
    push(1, 2, 1'b1, 32'h33333333, 1'b0, 1'b0, k + 6);
    push(1, 3, 1'b1, 32'hDEADCAFE, 1'b0, 1'b0, k + 10);
    bus1.boot_req = 1; bus1.boot_addr = 32'h30; bus1.boot_w_enb = 4'hF; bus1.boot_w_data = 32'h33333333;
    bus1.d_req = 1; bus1.d_addr = 32'h30; bus1.d_w_enb = 4'h0;
    bus1.i_req = 1; bus1.i_addr = 32'h10;
    tick();
    chk("simul_grant_boot", bus1.grant_id, 2'd1);
    tick();
    bus1.boot_req = 0;
    tick();
    tick();
    chk("simul_grant_data", bus1.grant_id, 2'd2);
    tick();
    tick();
    bus1.d_req = 0;
    tick();
    tick();
    chk("simul_grant_fetch", bus1.grant_id, 2'd3);
    tick();
    tick();
    bus1.i_req = 0;
    tick();

    // starvation: four data grants, then a forced fetch, repeated
    k = cyc;
    for (int j = 0; j < 10; j++) begin
      fetch = ((j % 5) == 4);
      push(1, fetch ? 3 : 2, 1'b1, fetch ? 32'h33333333 : 32'hDEADCAFE, 1'b0, 1'b0, k + 3 + 4 * j);
    end
    bus1.d_req = 1; bus1.d_addr = 32'h10; bus1.d_w_enb = 4'h0;
    bus1.i_req = 1; bus1.i_addr = 32'h30;
    for (int j = 0; j < 10; j++) begin
      fetch = ((j % 5) == 4);
      tick();
      chk("starve_grant_id", bus1.grant_id, fetch ? 2'd3 : 2'd2);
      chk("starve_counter", u_dut.cnt_q, fetch ? 0 : (j % 5) + 1);
      tick();
      tick();
      if (j == 9) begin
        bus1.d_req = 0;
        bus1.i_req = 0;
      end
      tick();
    end

    // inputs latched at grant; req held high starts the next transaction
    k = cyc;
    push(1, 2, 1'b0, 32'h0, 1'b0, 1'b0, k + 2);
    push(1, 2, 1'b1, 32'h55555555, 1'b0, 1'b0, k + 6);
    bus1.d_req = 1; bus1.d_addr = 32'h40; bus1.d_w_enb = 4'hF; bus1.d_w_data = 32'h55555555;
    tick();
    bus1.d_w_data = 32'h66666666;
    bus1.d_addr   = 32'h44;
    #1;
    chk("hold_mem_w_data", bus1.mem_w_data, 32'h55555555);
    chk("hold_mem_addr", bus1.mem_addr, 32'h40);
    tick();
    bus1.d_w_enb = 4'h0;
    bus1.d_addr  = 32'h40;
    tick();
    chk("hold_idle_busy", bus1.busy, 1'b0);
    chk("hold_idle_grant_id", bus1.grant_id, 2'd0);
    tick();
    chk("hold_regrant_id", bus1.grant_id, 2'd2);
    chk("hold_regrant_r_enb", bus1.mem_r_enb, 1'b1);
    tick();
    tick();
    bus1.d_req = 0;
    tick();

    // asynchronous reset during WAIT on the READ_LAT=3 instance
    bus3.i_req = 1; bus3.i_addr = 32'h50;
    tick();
    chk("rst3_access_r_enb", bus3.mem_r_enb, 1'b1);
    tick();
    tick();
    #2;
    rst_n3 = 1'b0;
    bus3.i_req = 0;
    #1;
    chk("rst3_busy", bus3.busy, 1'b0);
    chk("rst3_mem_r_enb", bus3.mem_r_enb, 1'b0);
    chk("rst3_grant_id", bus3.grant_id, 2'd0);
    chk("rst3_i_r_data", bus3.i_r_data, 32'h0);
    tick();
    tick();
    rst_n3 = 1'b1;
    repeat (6) tick();
    k = cyc;
    push(3, 3, 1'b1, 32'hC0DE_0003, 1'b0, 1'b0, k + 5);
    bus3.i_req = 1; bus3.i_addr = 32'h54;
    tick();
    chk("rst3_after_grant_id", bus3.grant_id, 2'd3);
    repeat (4) tick();
    bus3.i_req = 0;
    tick();

    for (int w = 0; w < 20 && sbq.size() != 0; w++) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
